ula_arbitro: RTL
================

ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all data ports below are WIDTH bits.
REQ-002 Ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  requester N operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  3  op_sel code: 000 add, 001 sub, 010 and, 011 or, 100 nand, 101 xnor, 110 not A, 111 pass A.
- req0_cin / req1_cin  in  1  carry-in for add, borrow-in for sub, ignored otherwise.
- ula_a, ula_b  out  WIDTH  shared ALU operands.
- ula_op_sel  out  3  shared ALU operation select.
- ula_cin, ula_bin  out  1  shared ALU carry-in and borrow-in.
- ula_resultado  in  WIDTH  ALU result.
- ula_cout, ula_bout  in  1  ALU carry-out and borrow-out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response: 0 or 1.
- rsp_resultado  out  WIDTH  captured ALU result.
- rsp_flag  out  1  ula_cout for op 000, ula_bout for op 001, 0 for all other ops.
- busy  out  1  high in EXEC and RESP.
- ops_done  out  16  count of completed response handshakes.
REQ-003 Reset is synchronous and active-high on rst, sampled on clk's rising edge; there is one clock, clk.

Function
REQ-004 FSM states: IDLE, EXEC, RESP.
REQ-005 IDLE, neither valid -> stay in IDLE.
REQ-006 IDLE, any valid -> grant one requester, assert its reqN_ready combinationally in that cycle only, latch a/b/op/cin/id into operand registers, go to EXEC.
REQ-007 Grant rule when only one valid: grant that one.
REQ-008 Grant rule when both valid: grant the requester indicated by the round-robin pointer prio.
REQ-009 prio is set to the non-granted requester on every grant.
REQ-010 reqN_ready is 0 in EXEC and RESP and is never high for both requesters.
REQ-011 ula_a, ula_b and ula_op_sel are driven directly from the operand registers in all states.
REQ-012 ula_cin = latched cin when op=000, else 0; ula_bin = latched cin when op=001, else 0.
REQ-013 EXEC lasts exactly one cycle: capture ula_resultado into rsp_resultado, capture the flag per REQ-002 into rsp_flag, go to RESP.
REQ-014 RESP: rsp_valid=1; rsp_id, rsp_resultado and rsp_flag are held stable until the handshake.
REQ-015 RESP with rsp_ready=1: increment ops_done, return to IDLE.
REQ-016 ops_done wraps from 0xFFFF to 0x0000.
REQ-017 RESP with rsp_ready=0: remain in RESP; operand registers hold.
REQ-018 Latency: acceptance in cycle T -> rsp_valid high in cycle T+2.
REQ-019 Minimum spacing between acceptances is 3 cycles; there is no bypass from RESP directly to a new grant.
REQ-020 Requester inputs are ignored outside the acceptance cycle; changes on them after acceptance have no effect on the operation in progress.
REQ-021 busy = (state != IDLE).

Reset
REQ-022 rst=1 on a rising edge -> state IDLE, prio=0, operand registers 0, rsp_resultado 0, rsp_flag 0, rsp_id 0, ops_done 0.
REQ-023 Outputs following reset: rsp_valid 0, busy 0, req0_ready and req1_ready 0 while rst is high.
REQ-024 rst in EXEC or RESP discards the in-flight operation: no response is produced and ops_done is not incremented.
REQ-025 rst has priority over every simultaneous event, including a grant or a response handshake in the same cycle.

Verification
REQ-026 Single request: req0 add with A=5, B=7, cin=1, rsp_ready=1 -> req0_ready pulses in cycle T; in T+2 rsp_valid=1, rsp_resultado=13, rsp_flag=0, rsp_id=0; ops_done=1.
REQ-027 Carry wrap: req1 add with A=0xFFFFFFFF, B=1, cin=0 -> rsp_resultado=0x00000000, rsp_flag=1, rsp_id=1.
REQ-028 Borrow: req1 sub with A=3, B=5, cin=0 -> rsp_resultado=0xFFFFFFFE, rsp_flag=1; same op with A=5, B=3 -> rsp_resultado=2, rsp_flag=0.
REQ-029 Round robin: both valid continuously after reset, 4 ops, rsp_ready=1 -> rsp_id sequence 0,1,0,1, acceptances 3 cycles apart, ops_done=4, never both readies high.
REQ-030 Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_resultado, rsp_flag, rsp_id and ula_* stable; reqN_ready=0 throughout; exactly one ops_done increment when rsp_ready rises.
REQ-031 Reset mid-operation: rst in EXEC -> next cycle state IDLE, rsp_valid=0, ops_done=0; with req1 valid, req0 valid and prio=0, req0 is granted first.

Source files
------------

// File: rtl/ula_arbitro.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight at a time: grant in IDLE, one EXEC cycle, then hold the response in RESP.
module ula_arbitro #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_op_sel,
  output logic             ula_cin,
  output logic             ula_bin,
  input  logic [WIDTH-1:0] ula_resultado,
  input  logic             ula_cout,
  input  logic             ula_bout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_resultado,
  output logic             rsp_flag,
  output logic             busy,
  output logic [15:0]      ops_done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_flag_q, rsp_flag_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      ops_q, ops_d;
  logic             grant0, grant1;

  // Single valid wins outright; when both are valid the round-robin pointer decides.
  always_comb begin
    grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
    grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || prio_q);
  end

  assign req0_ready    = grant0 && !rst;
  assign req1_ready    = grant1 && !rst;
  assign ula_a         = a_q;
  assign ula_b         = b_q;
  assign ula_op_sel    = op_q;
  assign ula_cin       = (op_q == OP_ADD) && cin_q;
  assign ula_bin       = (op_q == OP_SUB) && cin_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_resultado = rsp_res_q;
  assign rsp_flag      = rsp_flag_q;
  assign busy          = busy_q;
  assign ops_done      = ops_q;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_res_d   = rsp_res_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_id_d    = rsp_id_q;
    ops_d       = ops_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          cin_d   = req0_cin;
          id_d    = 1'b0;
          prio_d  = 1'b1;
          state_d = EXEC;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          cin_d   = req1_cin;
          id_d    = 1'b1;
          prio_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d = ula_resultado;
        case (op_q)
          OP_ADD:  rsp_flag_d = ula_cout;
          OP_SUB:  rsp_flag_d = ula_bout;
          default: rsp_flag_d = 1'b0;
        endcase
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // Reset overrides any grant or handshake happening in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'b000;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flag_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ops_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ops_q       <= ops_d;
    end
  end

endmodule
